// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Desc     : Shared FSM state encoding, legal parameter ranges and the
//            baud divider computation for the UART transmit generator.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;
    localparam int DIV_MIN       = 4;
    localparam int BIT_CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_e;

    // Truncating divide; a zero rate yields 0 so the range check can reject it.
    function automatic int calc_div(input int clk_hz, input int baud);
        if (baud <= 0) begin
            return 0;
        end
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Desc     : Bit-period clock enable: counts 0..DIV-1, ticks on DIV-1,
//            synchronous clear restarts the period.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W  = (DIV > 2) ? $clog2(DIV) : 2;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = w_last && !clr;

endmodule
`default_nettype wire

// File: rtl/uart_tx_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_gen
// Desc     : FIFO-fed UART transmitter; fetches one word per frame and
//            serialises start, data (LSB first), optional parity and stop bits.
//            Parity is built only when UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int COUNT_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 rd_en,
    input  logic [DATA_BITS-1:0] rd_data,
    input  logic [COUNT_W-1:0]   rd_count,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int DIV = calc_div(CLK_HZ, BAUD_RATE);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_LOAD   = ST_LOAD;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = ST_PARITY;
`endif
    localparam logic [2:0] S_STOP   = ST_STOP;

    localparam logic [BIT_CNT_W-1:0] C_LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] C_LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

    generate
        if ((DATA_BITS < DATA_BITS_MIN) || (DATA_BITS > DATA_BITS_MAX)) begin : g_err_data_bits
            $error("uart_tx_gen: DATA_BITS out of range");
        end
        if ((STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX)) begin : g_err_stop_bits
            $error("uart_tx_gen: STOP_BITS out of range");
        end
        if (DIV < DIV_MIN) begin : g_err_div
            $error("uart_tx_gen: CLK_HZ/BAUD_RATE below minimum divider");
        end
        if (COUNT_W < 1) begin : g_err_count_w
            $error("uart_tx_gen: COUNT_W must be positive");
        end
    endgenerate

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [BIT_CNT_W-1:0] w_bit_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 w_tick;
    logic                 w_clr;
    logic                 w_done;
    logic                 w_par_bit;

`ifdef UART_TX_PARITY_EN
    logic r_par;
    logic w_par_nxt;

    assign w_par_bit = r_par;
`else
    logic w_unused_parity;

    assign w_unused_parity = parity_odd;
    assign w_par_bit       = 1'b1;
`endif

    // Divider held at zero outside the bit-timed states so START begins a full period.
    assign w_clr = (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_LOAD);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_cnt;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (rd_count != '0) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_shift_nxt = rd_data;
                w_bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
                w_par_nxt   = (^rd_data) ^ parity_odd;
`endif
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == C_LAST_DATA) begin
                        w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == C_LAST_STOP) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Line level is registered from the next state so tx never glitches.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
        end
    end
`endif

    assign w_done = (r_state == S_STOP) && w_tick && (r_bit_cnt == C_LAST_STOP);

    assign tx    = r_tx;
    assign rd_en = (r_state == S_FETCH);
    assign busy  = (r_state != S_IDLE);
    assign done  = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_gen
// Desc     : Scoreboard bench for uart_tx_gen (DIV=10, 8 data bits, 2 stops).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_gen;

    localparam int CLK_HZ    = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DIV       = 10;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 2;
    localparam int COUNT_W   = 12;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int FRAME_CLKS = FRAME_BITS * DIV;

    typedef struct packed {
        logic [DATA_BITS-1:0] w;
        logic                 podd;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rd_en;
    logic [DATA_BITS-1:0] rd_data = '0;
    logic [COUNT_W-1:0]   rd_count;
    logic                 parity_odd = 1'b0;
    logic                 tx;
    logic                 busy;
    logic                 done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_gen #(
        .CLK_HZ    (CLK_HZ),
        .BAUD_RATE (BAUD_RATE),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .COUNT_W   (COUNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_count   (rd_count),
        .parity_odd (parity_odd),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    // FIFO model: data appears one clk after rd_en.
    logic [DATA_BITS-1:0] mem [0:63];
    int push_cnt = 0;
    int pop_cnt  = 0;
    assign rd_count = COUNT_W'(push_cnt - pop_cnt);

    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            rd_data <= mem[pop_cnt[5:0]];
            pop_cnt <= pop_cnt + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rden_cnt      = 0;
    int done_cnt      = 0;
    int last_rden_cyc = 0;
    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            rden_cnt      <= rden_cnt + 1;
            last_rden_cyc <= cyc;
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
        end
    end

    exp_t exp_q[$];
    logic cap_tx   [0:255];
    logic cap_done [0:255];
    logic cap_busy [0:255];

    task automatic push_word(input logic [DATA_BITS-1:0] w);
        mem[push_cnt[5:0]] = w;
        exp_q.push_back('{w: w, podd: parity_odd});
        push_cnt = push_cnt + 1;
    endtask

    function automatic logic [15:0] build_frame(input exp_t e);
        logic [15:0] bits;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) bits[1 + i] = e.w[i];
`ifdef UART_TX_PARITY_EN
        bits[1 + DATA_BITS] = (^e.w) ^ e.podd;
`endif
        return bits;
    endfunction

    task automatic wait_start(output bit timed_out, output int at);
        timed_out = 1'b1;
        at        = 0;
        for (int i = 0; i < 500 && timed_out; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                timed_out = 1'b0;
                at        = cyc;
            end
        end
    endtask

    // First sample is the current negedge (start bit already seen).
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap_tx[i]   = tx;
            cap_done[i] = done;
            cap_busy[i] = busy;
        end
    endtask

    function automatic int line_errors(input logic [15:0] bits);
        int errs = 0;
        for (int b = 0; b < FRAME_BITS; b++)
            for (int j = 0; j < DIV; j++)
                if (cap_tx[b * DIV + j] !== bits[b]) errs++;
        return errs;
    endfunction

    function automatic int done_errors();
        int errs = 0;
        for (int k = 0; k < FRAME_CLKS; k++)
            if (cap_done[k] !== (k == FRAME_CLKS - 1)) errs++;
        return errs;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (tx !== 1'b1)    begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
        if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle();
        int bad_rd = 0, bad_busy = 0, bad_done = 0, bad_tx = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rd_en !== 1'b0) bad_rd++;
            if (busy !== 1'b0)  bad_busy++;
            if (done !== 1'b0)  bad_done++;
            if (tx !== 1'b1)    bad_tx++;
        end
        checks += 4;
        if (bad_rd != 0)   begin failures++; $display("FAIL idle_rd_en high_cycles=%0d exp=0", bad_rd); end
        if (bad_busy != 0) begin failures++; $display("FAIL idle_busy high_cycles=%0d exp=0", bad_busy); end
        if (bad_done != 0) begin failures++; $display("FAIL idle_done high_cycles=%0d exp=0", bad_done); end
        if (bad_tx != 0)   begin failures++; $display("FAIL idle_tx low_cycles=%0d exp=0", bad_tx); end
    endtask

    task automatic test_single_frame();
        int rden0 = rden_cnt, done0 = done_cnt, at, errs, bbad = 0;
        bit to;
        exp_t e;
        logic [15:0] bits;
        parity_odd = 1'b0;
        push_word(8'hA5);
        wait_start(to, at);
        checks++;
        if (to) begin
            failures++; $display("FAIL single_start timeout got=none exp=start_bit");
            return;
        end
        e    = exp_q.pop_front();
        bits = build_frame(e);
        checks++;
        if (at - last_rden_cyc !== 2) begin
            failures++; $display("FAIL single_rden_to_start got=%0d exp=2", at - last_rden_cyc);
        end
        capture(FRAME_CLKS);
        for (int b = 0; b < FRAME_BITS; b++) begin
            errs = 0;
            for (int j = 0; j < DIV; j++)
                if (cap_tx[b * DIV + j] !== bits[b]) errs++;
            checks++;
            if (errs != 0) begin
                failures++; $display("FAIL single_bit%0d bad_samples=%0d exp_level=%b", b, errs, bits[b]);
            end
        end
        for (int k = 0; k < FRAME_CLKS; k++) if (cap_busy[k] !== 1'b1) bbad++;
        checks += 2;
        if (done_errors() != 0) begin failures++; $display("FAIL single_done_timing bad=%0d exp=0", done_errors()); end
        if (bbad != 0)          begin failures++; $display("FAIL single_busy low_cycles=%0d exp=0", bbad); end
        @(negedge clk);
        checks += 4;
        if (rden_cnt - rden0 !== 1) begin failures++; $display("FAIL single_rd_en_count got=%0d exp=1", rden_cnt - rden0); end
        if (done_cnt - done0 !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - done0); end
        if (tx !== 1'b1)            begin failures++; $display("FAIL single_after_tx got=%b exp=1", tx); end
        if (busy !== 1'b0)          begin failures++; $display("FAIL single_after_busy got=%b exp=0", busy); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_parity();
        int at, errs;
        bit to;
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            parity_odd = p[0];
            push_word(8'h07);
            wait_start(to, at);
            checks++;
            if (to) begin
                failures++; $display("FAIL parity%0d_start timeout got=none exp=start_bit", p);
                return;
            end
            e = exp_q.pop_front();
            capture(FRAME_CLKS);
            errs = line_errors(build_frame(e));
            checks++;
            if (errs != 0) begin failures++; $display("FAIL parity%0d_frame bad_samples=%0d exp=0", p, errs); end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (cap_tx[(1 + DATA_BITS) * DIV + DIV / 2] !== ~p[0]) begin
                failures++;
                $display("FAIL parity%0d_bit got=%b exp=%b", p, cap_tx[(1 + DATA_BITS) * DIV + DIV / 2], ~p[0]);
            end
`endif
            repeat (5) @(negedge clk);
        end
        parity_odd = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rden0 = rden_cnt, done0 = done_cnt, at, errs, prev_end = 0;
        bit to;
        exp_t e;
        push_word(8'h3C);
        push_word(8'h81);
        push_word(8'hFF);
        for (int f = 0; f < 3; f++) begin
            wait_start(to, at);
            checks++;
            if (to) begin
                failures++; $display("FAIL b2b_frame%0d_start timeout got=none exp=start_bit", f);
                return;
            end
            if (f > 0) begin
                checks++;
                if (at - prev_end !== 4) begin
                    failures++; $display("FAIL b2b_gap%0d got=%0d exp=3", f, at - prev_end - 1);
                end
            end
            e = exp_q.pop_front();
            capture(FRAME_CLKS);
            prev_end = cyc;
            errs = line_errors(build_frame(e));
            checks += 2;
            if (errs != 0)          begin failures++; $display("FAIL b2b_frame%0d bad_samples=%0d exp=0", f, errs); end
            if (done_errors() != 0) begin failures++; $display("FAIL b2b_done%0d bad=%0d exp=0", f, done_errors()); end
        end
        @(negedge clk);
        checks += 2;
        if (rden_cnt - rden0 !== 3) begin failures++; $display("FAIL b2b_rd_en_count got=%0d exp=3", rden_cnt - rden0); end
        if (done_cnt - done0 !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", done_cnt - done0); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int at, rden0, bad_tx = 0;
        bit to;
        exp_t e;
        push_word(8'h5A);
        wait_start(to, at);
        checks++;
        if (to) begin
            failures++; $display("FAIL rstmid_start timeout got=none exp=start_bit");
            return;
        end
        e = exp_q.pop_front();
        repeat (44) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks += 3;
        if (tx !== 1'b1)   begin failures++; $display("FAIL rstmid_tx got=%b exp=1 (word %h)", tx, e.w); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
        @(negedge clk);
        rst   = 1'b0;
        rden0 = rden_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
        end
        checks += 2;
        if (rden_cnt - rden0 !== 0) begin failures++; $display("FAIL rstmid_reread got=%0d exp=0", rden_cnt - rden0); end
        if (bad_tx != 0)            begin failures++; $display("FAIL rstmid_tx_after low_cycles=%0d exp=0", bad_tx); end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, 9600, line bit rate; DIV = CLK_HZ/BAUD_RATE (integer, truncated).
REQ-003 SHALL have parameter DATA_BITS, 8, payload bits per frame, legal 5..9.
REQ-004 SHALL have parameter STOP_BITS, 1, stop bits per frame, legal 1 or 2.
REQ-005 SHALL have parameter COUNT_W, 12, width of FIFO occupancy input.
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port rd_en  output  1  FIFO read strobe, one clk wide.
REQ-009 SHALL have port rd_data  input  DATA_BITS  FIFO read data, valid one clk after rd_en.
REQ-010 SHALL have port rd_count  input  COUNT_W  FIFO words available.
REQ-011 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity compiled out.
REQ-012 SHALL have port tx  output  1  serial line, idle high.
REQ-013 SHALL have port busy  output  1  high from FETCH until end of last stop bit.
REQ-014 SHALL have port done  output  1  one-clk pulse when a frame's last stop bit completes.

Function
REQ-015 SHALL use a single clk domain; bit timing by clock-enable divider, no derived clocks.
REQ-016 SHALL implement states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-017 IDLE -> FETCH when rd_count != 0; otherwise remain IDLE, tx = 1.
REQ-018 rd_en SHALL be high exactly the one cycle spent in FETCH; FETCH -> LOAD unconditionally.
REQ-019 LOAD SHALL capture rd_data (and parity_odd) into the shift register and drive tx low from the next edge; tx falls 2 clks after the rd_en cycle.
REQ-020 Divider SHALL reset to 0 on entering START and each bit SHALL last exactly DIV clks.
REQ-021 DATA SHALL send DATA_BITS bits LSB first; then PARITY (if compiled in); then STOP_BITS ones.
REQ-022 done SHALL pulse on the last clk of the final stop bit; FSM returns to IDLE next edge.
REQ-023 Back-to-back frames: IDLE re-evaluates rd_count on its first cycle; inter-frame idle gap exactly 3 clks.
REQ-024 rd_count changes during a frame SHALL not affect the frame in flight.
REQ-025 Parameters out of range or DIV < 4 SHALL cause an elaboration error.

Reset
REQ-026 On rst: tx = 1, rd_en = 0, busy = 0, done = 0, FSM = IDLE, divider and bit counter = 0.
REQ-027 rst mid-frame SHALL abort immediately; the captured word is discarded, not re-read.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: PARITY state sends XOR(data) ^ parity_odd after data bits.
REQ-029 Macro UART_TX_PARITY_EN undefined: PARITY state and logic absent; DATA -> STOP directly; parity_odd unused.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, DIV computation function and legal-range constants.
REQ-031 Sub-module uart_baud_tick (counter with sync clear, tick at DIV-1) SHALL generate bit timing.

Verification (CLK_HZ=1_000_000, BAUD_RATE=100_000, DIV=10)
REQ-032 rd_count=1, rd_data=8'hA5, 8N1 -> one rd_en; tx = 0,1,0,1,0,0,1,0,1,1, each 10 clks; done once.
REQ-033 UART_TX_PARITY_EN, parity_odd=0, rd_data=8'h07 -> parity bit 1; parity_odd=1 -> parity bit 0; frame 11 bits.
REQ-034 rd_count=3, STOP_BITS=2 -> three frames, each 110 clks, 3-clk idle gaps, 3 rd_en pulses, 3 done pulses.
REQ-035 rst asserted 45 clks into frame -> tx high same cycle; after release with rd_count=0 no rd_en, tx stays 1.
REQ-036 rd_count=0 for 1000 clks -> rd_en, busy, done all 0, tx constant 1.
